// File: rtl/ram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// ram_fifo_pkg
// Shared constants, types and helpers for the 512x20 dpsram FIFO controller.
//
// Contents:
//   ADDR_W_DEF / DEPTH_DEF / CNT_W_DEF - default geometry of one RAM block
//   addr_t  - RAM address at the default geometry
//   cnt_t   - occupancy count at the default geometry (0..DEPTH inclusive)
//   af_threshold() - occupancy at which almost-full asserts
// -----------------------------------------------------------------------------
package ram_fifo_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DEPTH_DEF  = 512;
    localparam int CNT_W_DEF  = ADDR_W_DEF + 1;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [CNT_W_DEF-1:0]  cnt_t;

    // The almost-full offset is programmed as a distance below DEPTH.
    // The offset is at most DEPTH-1, so the result is never below 1.
    function automatic logic [31:0] af_threshold(input logic [31:0] depth,
                                                 input logic [31:0] offset);
        return depth - offset;
    endfunction

endpackage : ram_fifo_pkg

// File: rtl/ram_fifo_ptr.sv
// -----------------------------------------------------------------------------
// ram_fifo_ptr
// Binary RAM pointer that wraps from DEPTH-1 back to 0. Used once for the
// write side and once for the read side of the FIFO controller.
//
// Ports:
//   ram_clk_i  in   RAM clock
//   rst_i      in   asynchronous reset, active-high (pointer -> 0)
//   inc_i      in   advance the pointer by one on the next edge
//   flush_i    in   synchronous clear to 0, overrides inc_i
//   ptr_o      out  current pointer value (RAM address)
// -----------------------------------------------------------------------------
module ram_fifo_ptr
    import ram_fifo_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              ram_clk_i,
    input  logic              rst_i,
    input  logic              inc_i,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] ptr_o
);

    // DEPTH is an exact power of two, so natural binary overflow is the wrap.
    // NOTE: sequential state is written with <= so every register samples the
    // pre-edge values of its inputs, independent of block evaluation order.
    always_ff @(posedge ram_clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_o <= '0;
        end else if (flush_i) begin
            ptr_o <= '0;
        end else if (inc_i) begin
            ptr_o <= ptr_o + ADDR_W'(1);
        end
    end

endmodule : ram_fifo_ptr

// File: rtl/ram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// ram_fifo_ctrl
// Synchronous FIFO controller for one 512x20 dpsram block. Owns the write and
// read pointers, the occupancy count and the status flags, and drives the RAM
// port enables/addresses. Data flows directly between user and RAM.
//
// Build option:
//   RAM_FIFO_ERR_FLAGS_EN - adds sticky overflow_o / underflow_o and err_clr_i.
//                           Without it, rejected requests are silently dropped.
//
// Ports:
//   ram_clk_i           in   RAM clock from the clock selection stage
//   rst_i               in   asynchronous reset, active-high
//   cfg_fifo_en_i       in   static enable; 0 freezes state, forces enables 0
//   cfg_almost_full_i   in   almost-full offset below DEPTH
//   cfg_almost_empty_i  in   almost-empty threshold
//   flush_i             in   synchronous clear of pointers, count and flags
//   push_i / pop_i      in   write / read requests
//   err_clr_i           in   clear sticky error flags (option only)
//   overflow_o          out  sticky: push seen while full (option only)
//   underflow_o         out  sticky: pop seen while empty (option only)
//   wr_en_o, wr_addr_o  out  RAM write port enable / address
//   rd_en_o, rd_addr_o  out  RAM read port enable / address
//   rd_valid_o          out  RAM read data valid, one cycle after rd_en_o
//   count_o             out  occupancy, 0..DEPTH
//   full_o, empty_o, almost_full_o, almost_empty_o  out  registered flags
// -----------------------------------------------------------------------------
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              ram_clk_i,
    input  logic              rst_i,
    input  logic              cfg_fifo_en_i,
    input  logic [ADDR_W-1:0] cfg_almost_full_i,
    input  logic [ADDR_W-1:0] cfg_almost_empty_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
`ifdef RAM_FIFO_ERR_FLAGS_EN
    input  logic              err_clr_i,
    output logic              overflow_o,
    output logic              underflow_o,
`endif
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              rd_valid_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o
);

    localparam int               DEPTH     = 2**ADDR_W;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic              push_acc;
    logic              pop_acc;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_next;
    logic              full_q;
    logic              empty_q;
    logic              almost_full_q;
    logic              almost_empty_q;
    logic              rd_valid_q;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;

    // Accept decisions use the registered flags, so a push into a FIFO that
    // is draining this very cycle is still rejected while full_q is set.
    assign push_acc = cfg_fifo_en_i & push_i & ~full_q  & ~flush_i;
    assign pop_acc  = cfg_fifo_en_i & pop_i  & ~empty_q & ~flush_i;

    ram_fifo_ptr #(.ADDR_W(ADDR_W)) u_wptr (
        .ram_clk_i (ram_clk_i),
        .rst_i     (rst_i),
        .inc_i     (push_acc),
        .flush_i   (flush_i),
        .ptr_o     (wptr)
    );

    ram_fifo_ptr #(.ADDR_W(ADDR_W)) u_rptr (
        .ram_clk_i (ram_clk_i),
        .rst_i     (rst_i),
        .inc_i     (pop_acc),
        .flush_i   (flush_i),
        .ptr_o     (rptr)
    );

    // Full and empty come from the count, so pointer equality is never
    // ambiguous. Push+pop together leaves the count unchanged.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        count_next = count_q;
        if (flush_i) begin
            count_next = '0;
        end else if (push_acc && !pop_acc) begin
            count_next = count_q + CNT_W'(1);
        end else if (pop_acc && !push_acc) begin
            count_next = count_q - CNT_W'(1);
        end
    end

    // Flags are registered from count_next so they line up with count_q.
    // A flush drives count_next to 0, which reproduces the reset flag values
    // because the almost-full threshold is always at least 1.
    always_ff @(posedge ram_clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            rd_valid_q     <= 1'b0;
        end else begin
            count_q        <= count_next;
            full_q         <= (count_next == DEPTH_CNT);
            empty_q        <= (count_next == '0);
            almost_full_q  <= (32'(count_next) >=
                               af_threshold(32'(DEPTH), 32'(cfg_almost_full_i)));
            almost_empty_q <= (count_next <= CNT_W'(cfg_almost_empty_i));
            rd_valid_q     <= pop_acc;
        end
    end

`ifdef RAM_FIFO_ERR_FLAGS_EN
    // Sticky request errors; a new error in the same cycle as err_clr_i wins.
    always_ff @(posedge ram_clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (flush_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (push_i && full_q && cfg_fifo_en_i) begin
                overflow_o <= 1'b1;
            end else if (err_clr_i) begin
                overflow_o <= 1'b0;
            end
            if (pop_i && empty_q && cfg_fifo_en_i) begin
                underflow_o <= 1'b1;
            end else if (err_clr_i) begin
                underflow_o <= 1'b0;
            end
        end
    end
`endif

    assign wr_en_o        = push_acc;
    assign wr_addr_o      = wptr;
    assign rd_en_o        = pop_acc;
    assign rd_addr_o      = rptr;
    assign rd_valid_o     = rd_valid_q;
    assign count_o        = count_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = almost_full_q;
    assign almost_empty_o = almost_empty_q;

endmodule : ram_fifo_ctrl

// File: tb/tb_ram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_fifo_ctrl
// Self-checking bench for ram_fifo_ctrl. A behavioural 512x20 RAM is wired to
// the controller's port signals; pushed data words are queued and compared
// against the RAM output whenever rd_valid_o is high. A small occupancy model
// predicts enables, addresses, count and flags every cycle.
// -----------------------------------------------------------------------------
module tb_ram_fifo_ctrl;
    import ram_fifo_pkg::*;

    localparam int AW    = ADDR_W_DEF;
    localparam int CW    = AW + 1;
    localparam int DEPTH = DEPTH_DEF;
    localparam int AF_OFS = 4;
    localparam int AE_THR = 2;

    logic          ram_clk_i;
    logic          rst_i;
    logic          cfg_fifo_en_i;
    logic [AW-1:0] cfg_almost_full_i;
    logic [AW-1:0] cfg_almost_empty_i;
    logic          flush_i;
    logic          push_i;
    logic          pop_i;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic          rd_en_o;
    logic [AW-1:0] rd_addr_o;
    logic          rd_valid_o;
    logic [CW-1:0] count_o;
    logic          full_o;
    logic          empty_o;
    logic          almost_full_o;
    logic          almost_empty_o;
`ifdef RAM_FIFO_ERR_FLAGS_EN
    logic          err_clr_i;
    logic          overflow_o;
    logic          underflow_o;
`endif

    ram_fifo_ctrl dut (
        .ram_clk_i          (ram_clk_i),
        .rst_i              (rst_i),
        .cfg_fifo_en_i      (cfg_fifo_en_i),
        .cfg_almost_full_i  (cfg_almost_full_i),
        .cfg_almost_empty_i (cfg_almost_empty_i),
        .flush_i            (flush_i),
        .push_i             (push_i),
        .pop_i              (pop_i),
`ifdef RAM_FIFO_ERR_FLAGS_EN
        .err_clr_i          (err_clr_i),
        .overflow_o         (overflow_o),
        .underflow_o        (underflow_o),
`endif
        .wr_en_o            (wr_en_o),
        .wr_addr_o          (wr_addr_o),
        .rd_en_o            (rd_en_o),
        .rd_addr_o          (rd_addr_o),
        .rd_valid_o         (rd_valid_o),
        .count_o            (count_o),
        .full_o             (full_o),
        .empty_o            (empty_o),
        .almost_full_o      (almost_full_o),
        .almost_empty_o     (almost_empty_o)
    );

    initial ram_clk_i = 1'b0;
    always #5 ram_clk_i = ~ram_clk_i;

    // Behavioural RAM driven by the controller's port signals.
    logic [19:0] mem [DEPTH];
    logic [19:0] wr_data;
    logic [19:0] rd_data;

    always @(posedge ram_clk_i) begin
        if (wr_en_o) mem[wr_addr_o] <= wr_data;
        if (rd_en_o) rd_data <= mem[rd_addr_o];
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [19:0] sb [$];
    logic [19:0] data_ctr;
    logic        cfg_en;

    int m_count, m_wptr, m_rptr;
    bit m_full, m_empty, m_af, m_ae, m_rd_valid;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_wptr = 0; m_rptr = 0; m_rd_valid = 1'b0;
        m_full = 1'b0; m_empty = 1'b1; m_af = 1'b0; m_ae = 1'b1;
        sb.delete();
    endtask

    task automatic model_flags();
        m_full  = (m_count == DEPTH);
        m_empty = (m_count == 0);
        m_af    = (m_count >= DEPTH - AF_OFS);
        m_ae    = (m_count <= AE_THR);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"},  32'(count_o),        0);
        check({tag, "_empty"},  32'(empty_o),        1);
        check({tag, "_full"},   32'(full_o),         0);
        check({tag, "_ae"},     32'(almost_empty_o), 1);
        check({tag, "_af"},     32'(almost_full_o),  0);
        check({tag, "_rdv"},    32'(rd_valid_o),     0);
        check({tag, "_wren"},   32'(wr_en_o),        0);
        check({tag, "_rden"},   32'(rd_en_o),        0);
        check({tag, "_wraddr"}, 32'(wr_addr_o),      0);
        check({tag, "_rdaddr"}, 32'(rd_addr_o),      0);
    endtask

    // One clock: drive at the falling edge, check port outputs before the
    // rising edge, then check registered state just after it.
    task automatic cycle(input logic p, input logic q, input logic f);
        logic pa, qa;
        @(negedge ram_clk_i);
        push_i = p; pop_i = q; flush_i = f; cfg_fifo_en_i = cfg_en;
        wr_data = data_ctr;
        #1;
        pa = cfg_en & p & !m_full  & !f;
        qa = cfg_en & q & !m_empty & !f;
        check("wr_en",   32'(wr_en_o),   32'(pa));
        check("rd_en",   32'(rd_en_o),   32'(qa));
        check("wr_addr", 32'(wr_addr_o), m_wptr);
        check("rd_addr", 32'(rd_addr_o), m_rptr);
        if (pa) begin
            sb.push_back(data_ctr);
            data_ctr = data_ctr + 20'd1;
        end
        @(posedge ram_clk_i);
        if (f) begin
            m_count = 0; m_wptr = 0; m_rptr = 0;
            sb.delete();
        end else begin
            if (pa) m_wptr = (m_wptr + 1) % DEPTH;
            if (qa) m_rptr = (m_rptr + 1) % DEPTH;
            m_count = m_count + int'(pa) - int'(qa);
        end
        m_rd_valid = qa;
        model_flags();
        #1;
        check("count",    32'(count_o),        m_count);
        check("full",     32'(full_o),         32'(m_full));
        check("empty",    32'(empty_o),        32'(m_empty));
        check("af",       32'(almost_full_o),  32'(m_af));
        check("ae",       32'(almost_empty_o), 32'(m_ae));
        check("rd_valid", 32'(rd_valid_o),     32'(m_rd_valid));
        if (rd_valid_o && sb.size() > 0) begin
            check("rd_data", 32'(rd_data), 32'(sb.pop_front()));
        end
    endtask

    task automatic pulse_reset();
        @(negedge ram_clk_i);
        push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_state("rst_mid");
        model_reset();
        @(negedge ram_clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0;
        cfg_en = 1'b1;
        cfg_fifo_en_i = 1'b1;
        cfg_almost_full_i = AW'(AF_OFS);
        cfg_almost_empty_i = AW'(AE_THR);
        flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
        wr_data = '0;
        data_ctr = 20'h1000;
`ifdef RAM_FIFO_ERR_FLAGS_EN
        err_clr_i = 1'b0;
`endif
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_state("rst_init");
        model_reset();
        @(negedge ram_clk_i);
        rst_i = 1'b0;

        // Pop on empty is ignored.
        cycle(1'b0, 1'b1, 1'b0);
        check("pop_empty_rdv", 32'(rd_valid_o), 0);

        // Fill to DEPTH, checking the almost-full / almost-empty boundaries.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (m_count == 2)   check("ae_at_2",   32'(almost_empty_o), 1);
            if (m_count == 3)   check("ae_fall_3", 32'(almost_empty_o), 0);
            if (m_count == 507) check("af_at_507", 32'(almost_full_o),  0);
            if (m_count == 508) check("af_rise_508", 32'(almost_full_o), 1);
        end
        check("full_at_512", 32'(full_o), 1);

        // Push into a full FIFO is rejected.
        cycle(1'b1, 1'b0, 1'b0);
        check("count_hold_513", 32'(count_o), DEPTH);
`ifdef RAM_FIFO_ERR_FLAGS_EN
        check("overflow_sticky", 32'(overflow_o), 1);
`endif

        // Push+pop while full: only the pop goes through.
        cycle(1'b1, 1'b1, 1'b0);
        check("pp_full_count", 32'(count_o), DEPTH - 1);
        check("pp_full_rdv",   32'(rd_valid_o), 1);

        // Drain to 10, then stream push+pop across the pointer wrap.
        while (m_count > 10) cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 600; i++) cycle(1'b1, 1'b1, 1'b0);
        check("stream_count", 32'(count_o), 10);

        // Flush at count 100 overrides a simultaneous push and pop.
        while (m_count < 100) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        check("flush_count", 32'(count_o), 0);
        check("flush_empty", 32'(empty_o), 1);

        // Disabled controller freezes state; re-enabling resumes.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
        cfg_en = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
        check("disabled_count", 32'(count_o), 5);
        cfg_en = 1'b1;
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);

        // Reset mid-stream with a read in flight.
        cycle(1'b0, 1'b1, 1'b0);
        pulse_reset();

        // Normal operation after reset.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("final_empty", 32'(empty_o), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ram_fifo_ctrl
